// File: rtl/pipe_tag_tracker.sv
// pipe_tag_tracker: per-stage transaction-tag tracker for the core pipeline.
// Issues non-zero tags into stage 0, moves tag+valid between stages on the
// per-stage advance strobes, checks in-order retirement at the last stage and
// flags live tags that get overwritten before release. Observes only.
module pipe_tag_tracker #(
  parameter int STAGES = 6,
  parameter int TAG_W  = 6
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          issue,
  input  logic [STAGES-1:0]             adv,
  input  logic [STAGES-1:0]             rem,
  input  logic                          flush,
  input  logic                          clr_err,
  output logic [STAGES*TAG_W-1:0]       tag_o,
  output logic [STAGES-1:0]             valid_o,
  output logic [$clog2(STAGES+1)-1:0]   occ_o,
  output logic                          order_err,
  output logic                          drop_err,
  output logic [TAG_W-1:0]              err_tag
);

  localparam int OCC_W = $clog2(STAGES + 1);
  localparam int LAST  = STAGES - 1;

  logic [TAG_W-1:0]  t_q [STAGES];
  logic [TAG_W-1:0]  t_d [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic [TAG_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  exp_q, exp_d;
  logic              order_err_q, order_err_d;
  logic              drop_err_q, drop_err_d;
  logic [TAG_W-1:0]  err_tag_q, err_tag_d;

  logic [STAGES-1:0] load;
  logic [STAGES-1:0] drain;
  logic [TAG_W-1:0]  nxt_tag;
  logic              retire;
  logic              order_hit;
  logic              drop_hit;
  logic [TAG_W-1:0]  drop_tag;
  logic              capture_ok;
  logic              unused_adv0;

  assign unused_adv0 = adv[0];

  // Tag increment modulo 2**TAG_W that never produces the empty tag 0.
  function automatic logic [TAG_W-1:0] inc(input logic [TAG_W-1:0] x);
    return (x == {TAG_W{1'b1}}) ? TAG_W'(1) : x + TAG_W'(1);
  endfunction

  assign nxt_tag = inc(cnt_q);

  // Which stages are being loaded this cycle and which are being drained by the stage after.
  always_comb begin
    load     = adv;
    load[0]  = issue;
    drain    = '0;
    for (int unsigned s = 0; s < STAGES - 1; s++) begin
      drain[s] = adv[s+1];
    end
  end

  // Stage contents: flush > issue/adv > rem > hold; adv reads pre-edge values.
  always_comb begin
    v_d = v_q;
    t_d = t_q;
    if (flush) begin
      v_d = '0;
      if (issue) begin
        v_d[0] = 1'b1;
        t_d[0] = nxt_tag;
      end
    end else begin
      if (issue) begin
        v_d[0] = 1'b1;
        t_d[0] = nxt_tag;
      end else if (rem[0]) begin
        v_d[0] = 1'b0;
      end
      for (int unsigned s = 1; s < STAGES; s++) begin
        if (adv[s]) begin
          v_d[s] = v_q[s-1];
          t_d[s] = t_q[s-1];
        end else if (rem[s]) begin
          v_d[s] = 1'b0;
        end
      end
    end
  end

  // Lost-tag detection; when several stages drop at once the lowest stage's tag is reported.
  always_comb begin
    drop_hit = 1'b0;
    drop_tag = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      if (!flush && !drop_hit && v_q[s] && !rem[s] && !drain[s] && load[s]) begin
        drop_hit = 1'b1;
        drop_tag = t_q[s];
      end
    end
  end

  // Tag counter, expected-retire tag, sticky error flags and first-error tag.
  always_comb begin
    retire     = rem[LAST] & v_q[LAST] & ~flush;
    order_hit  = retire && (t_q[LAST] != exp_q);
    cnt_d      = issue ? nxt_tag : cnt_q;
    exp_d      = exp_q;
    if (flush) begin
      exp_d = nxt_tag;
    end else if (retire) begin
      exp_d = inc(t_q[LAST]);
    end
    capture_ok  = clr_err | (~order_err_q & ~drop_err_q);
    order_err_d = (order_err_q & ~clr_err) | order_hit;
    drop_err_d  = (drop_err_q & ~clr_err) | drop_hit;
    err_tag_d   = clr_err ? '0 : err_tag_q;
    if (capture_ok && (order_hit || drop_hit)) begin
      err_tag_d = order_hit ? t_q[LAST] : drop_tag;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        t_q[s] <= '0;
      end
      v_q         <= '0;
      cnt_q       <= '0;
      exp_q       <= TAG_W'(1);
      order_err_q <= 1'b0;
      drop_err_q  <= 1'b0;
      err_tag_q   <= '0;
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        t_q[s] <= t_d[s];
      end
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      order_err_q <= order_err_d;
      drop_err_q  <= drop_err_d;
      err_tag_q   <= err_tag_d;
    end
  end

  // Output view: masked tags and occupancy count.
  always_comb begin
    occ_o = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      tag_o[s*TAG_W +: TAG_W] = v_q[s] ? t_q[s] : '0;
      occ_o = occ_o + {{(OCC_W-1){1'b0}}, v_q[s]};
    end
  end

  assign valid_o   = v_q;
  assign order_err = order_err_q;
  assign drop_err  = drop_err_q;
  assign err_tag   = err_tag_q;

endmodule

// File: tb/tb_pipe_tag_tracker.sv
// Self-checking bench for pipe_tag_tracker: directed scenarios followed by
// random traffic, every cycle compared against a tag-array reference model.
module tb_pipe_tag_tracker;

  localparam int S    = 6;
  localparam int W    = 6;
  localparam int OW   = $clog2(S + 1);
  localparam int MAXT = (1 << W) - 1;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            issue = 1'b0;
  logic [S-1:0]    adv = '0;
  logic [S-1:0]    rem = '0;
  logic            flush = 1'b0;
  logic            clr_err = 1'b0;
  logic [S*W-1:0]  tag_o;
  logic [S-1:0]    valid_o;
  logic [OW-1:0]   occ_o;
  logic            order_err;
  logic            drop_err;
  logic [W-1:0]    err_tag;

  int tests = 0;
  int fails = 0;

  // Reference model: one tag per stage, 0 meaning empty.
  int mt [S];
  int mcnt, mexp, merr_tag;
  bit mord, mdrop;

  always #5 clk = ~clk;

  pipe_tag_tracker #(.STAGES(S), .TAG_W(W)) dut (
    .clk(clk), .rstn(rstn), .issue(issue), .adv(adv), .rem(rem),
    .flush(flush), .clr_err(clr_err), .tag_o(tag_o), .valid_o(valid_o),
    .occ_o(occ_o), .order_err(order_err), .drop_err(drop_err), .err_tag(err_tag)
  );

  function automatic int tinc(input int x);
    return (x >= MAXT) ? 1 : x + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < S; s++) mt[s] = 0;
    mcnt = 0; mexp = 1; mord = 0; mdrop = 0; merr_tag = 0;
  endtask

  task automatic check_all(input string ph);
    logic [S*W-1:0] et;
    logic [S-1:0]   ev;
    int             occ;
    occ = 0;
    for (int s = 0; s < S; s++) begin
      et[s*W +: W] = W'(mt[s]);
      ev[s]        = (mt[s] != 0);
      occ          += (mt[s] != 0) ? 1 : 0;
    end
    chk({ph, ".tag_o"}, 64'(tag_o), 64'(et));
    chk({ph, ".valid_o"}, 64'(valid_o), 64'(ev));
    chk({ph, ".occ_o"}, 64'(occ_o), 64'(occ));
    chk({ph, ".order_err"}, 64'(order_err), 64'(mord));
    chk({ph, ".drop_err"}, 64'(drop_err), 64'(mdrop));
    chk({ph, ".err_tag"}, 64'(err_tag), 64'(merr_tag));
  endtask

  // Model of one clock edge from the rules: flush wins, then loads, then releases.
  task automatic model_edge(input bit i_iss, input logic [S-1:0] i_adv, input logic [S-1:0] i_rem,
                            input bit i_fl, input bit i_clr);
    int nt [S];
    bit oh, dh;
    int otag, dtag;
    bit was_clear;
    oh = 0; dh = 0; otag = 0; dtag = 0;
    was_clear = i_clr || (!mord && !mdrop);
    if (i_fl) begin
      for (int s = 0; s < S; s++) nt[s] = 0;
      if (i_iss) nt[0] = tinc(mcnt);
      mexp = tinc(mcnt);
    end else begin
      for (int s = 0; s < S; s++) begin
        bit ld, drained;
        int src;
        ld      = (s == 0) ? i_iss : i_adv[s];
        src     = (s == 0) ? tinc(mcnt) : mt[s-1];
        drained = (s < S - 1) ? i_adv[s+1] : 1'b0;
        nt[s]   = mt[s];
        if (ld) begin
          if (mt[s] != 0 && !i_rem[s] && !drained && !dh) begin
            dh = 1; dtag = mt[s];
          end
          nt[s] = src;
        end else if (i_rem[s]) begin
          nt[s] = 0;
        end
      end
      if (i_rem[S-1] && mt[S-1] != 0) begin
        if (mt[S-1] != mexp) begin
          oh = 1; otag = mt[S-1];
        end
        mexp = tinc(mt[S-1]);
      end
    end
    if (i_iss) mcnt = tinc(mcnt);
    if (i_clr) begin
      mord = 0; mdrop = 0; merr_tag = 0;
    end
    if (was_clear && (oh || dh)) merr_tag = oh ? otag : dtag;
    if (oh) mord = 1;
    if (dh) mdrop = 1;
    for (int s = 0; s < S; s++) mt[s] = nt[s];
  endtask

  task automatic step(input string ph, input bit i_iss, input logic [S-1:0] i_adv,
                      input logic [S-1:0] i_rem, input bit i_fl, input bit i_clr);
    @(negedge clk);
    issue = i_iss; adv = i_adv; rem = i_rem; flush = i_fl; clr_err = i_clr;
    model_edge(i_iss, i_adv, i_rem, i_fl, i_clr);
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock.
  task automatic mid_reset(input string ph);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all(ph);
    @(negedge clk);
    issue = 0; adv = '0; rem = '0; flush = 0; clr_err = 0;
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rstn = 1'b1;

    // Repeated issue into an undrained stage 0 loses tags 1 and 2.
    step("t1a", 1, '0, '0, 0, 0);
    step("t1b", 1, '0, '0, 0, 0);
    step("t1c", 1, '0, '0, 0, 0);
    chk("t1.tag0", 64'(tag_o[W-1:0]), 64'd3);
    chk("t1.drop", 64'(drop_err), 64'd1);
    chk("t1.err_tag", 64'(err_tag), 64'd1);
    chk("t1.occ", 64'(occ_o), 64'd1);
    step("t1clr", 0, '0, S'(1), 0, 1);
    chk("t1clr.drop", 64'(drop_err), 64'd0);
    step("t1flush", 0, '0, '0, 1, 0);

    // Single tag walks PF..WB, releasing behind itself, then retires in order.
    step("t2iss", 1, '0, '0, 0, 0);
    for (int s = 1; s < S; s++) step("t2walk", 0, S'(1) << s, S'(1) << (s - 1), 0, 0);
    step("t2ret", 0, '0, S'(1) << (S - 1), 0, 0);
    chk("t2.order", 64'(order_err), 64'd0);
    chk("t2.occ", 64'(occ_o), 64'd0);

    // Continuous full-pipe streaming across the tag wrap point.
    for (int i = 0; i < 70; i++) step("t3run", 1, {{(S-1){1'b1}}, 1'b0}, S'(1) << (S - 1), 0, 0);
    for (int i = 0; i < S; i++)
      step("t3drain", 0, {{(S-1){1'b1}}, 1'b0}, (S'(1) << (S - 1)) | S'(1), 0, 0);
    chk("t3.order", 64'(order_err), 64'd0);
    chk("t3.drop", 64'(drop_err), 64'd0);

    // Out-of-order retirement: B=2 retires while A=1 was expected.
    mid_reset("t4rst");
    step("t4a", 1, '0, '0, 0, 0);
    step("t4b", 1, S'(2), '0, 0, 0);
    step("t4relA", 0, '0, S'(2), 0, 0);
    step("t4mv", 0, S'(2), S'(1), 0, 0);
    for (int s = 2; s < S; s++) step("t4walk", 0, S'(1) << s, S'(1) << (s - 1), 0, 0);
    step("t4ret", 0, '0, S'(1) << (S - 1), 0, 0);
    chk("t4.order", 64'(order_err), 64'd1);
    chk("t4.err_tag", 64'(err_tag), 64'd2);
    step("t4clr", 0, '0, '0, 0, 1);
    chk("t4clr.order", 64'(order_err), 64'd0);
    chk("t4clr.err_tag", 64'(err_tag), 64'd0);

    // Flush with simultaneous issue keeps only the new tag and resyncs expectation.
    step("t5a", 1, '0, '0, 0, 0);
    step("t5b", 1, S'(2), '0, 0, 0);
    step("t5c", 1, S'(6), '0, 0, 0);
    step("t5fl", 1, S'(6), '0, 1, 0);
    chk("t5.occ", 64'(occ_o), 64'd1);
    chk("t5.tag0", 64'(tag_o[W-1:0]), 64'd6);
    for (int s = 1; s < S; s++) step("t5walk", 0, S'(1) << s, S'(1) << (s - 1), 0, 0);
    step("t5ret", 0, '0, S'(1) << (S - 1), 0, 0);
    chk("t5.order", 64'(order_err), 64'd0);

    // Bubble advanced over a releasing stage: empties it without a drop.
    step("t6a", 1, '0, '0, 0, 0);
    step("t6b", 0, S'(2), S'(1), 0, 0);
    step("t6c", 0, S'(4), S'(2), 0, 0);
    step("t6d", 0, S'(4), S'(4), 0, 0);
    chk("t6.valid", 64'(valid_o), 64'd0);
    chk("t6.drop", 64'(drop_err), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) mid_reset("rnd_rst");
      step("rnd", 1'($urandom_range(0, 1)), S'($urandom) & ~S'(1), S'($urandom) & S'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
